// File: rtl/flag_unit.sv
// Flag unit: 4-bit ALU flag register, a 4-deep LIFO for saving and restoring
// flags, a sticky stack-error indicator and a branch-condition evaluator.
// Flag bit order: [0] zero, [1] all-ones, [2] carry, [3] odd parity.
module flag_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  FLAG_status_in,
    input  logic        FLAG_update_en,
    input  logic        FLAG_push,
    input  logic        FLAG_pop,
    input  logic        FLAG_err_clr,
    input  logic [2:0]  FLAG_cond_sel,
    output logic        FLAG_cond_true,
    output logic [3:0]  FLAG_reg,
    output logic [15:0] FLAG_out,
    output logic        FLAG_stack_full,
    output logic        FLAG_stack_empty,
    output logic        FLAG_stack_err
);

    localparam logic [2:0] DEPTH = 3'd4;

    logic [3:0] flag_q;
    logic [3:0] flag_d;
    logic [3:0] stack_q [0:3];
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       err_q;
    logic       err_d;
    logic       is_full;
    logic       is_empty;
    logic       push_ok;
    logic       pop_ok;
    logic       op_error;
    logic [1:0] top_idx;

    assign is_full  = (count_q == DEPTH);
    assign is_empty = (count_q == 3'd0);
    // With count 1..4 the low two bits minus one always name the top entry.
    assign top_idx  = count_q[1:0] - 2'd1;

    // Decide which operation takes effect this cycle and compute next state.
    always_comb begin
        flag_d   = flag_q;
        count_d  = count_q;
        err_d    = err_q;
        push_ok  = FLAG_push & ~FLAG_pop & ~is_full;
        pop_ok   = FLAG_pop & ~FLAG_push & ~is_empty;
        // Conflicting push+pop, overflow and underflow all leave the stack alone.
        op_error = (FLAG_push & FLAG_pop)
                 | (FLAG_push & ~FLAG_pop & is_full)
                 | (FLAG_pop & ~FLAG_push & is_empty);

        if (push_ok) begin
            count_d = count_q + 3'd1;
        end

        // A successful pop overrides a same-cycle update; otherwise update applies.
        if (pop_ok) begin
            count_d = count_q - 3'd1;
            flag_d  = stack_q[top_idx];
        end else if (FLAG_update_en) begin
            flag_d = FLAG_status_in;
        end

        // New error beats a same-cycle clear.
        if (op_error) begin
            err_d = 1'b1;
        end else if (FLAG_err_clr) begin
            err_d = 1'b0;
        end
    end

    // Flag register, occupancy count and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q  <= 4'h0;
            count_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            flag_q  <= flag_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack storage; the pre-update flag value is what gets saved on a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                stack_q[i] <= 4'h0;
            end
        end else if (push_ok) begin
            stack_q[count_q[1:0]] <= flag_q;
        end
    end

    // Branch condition evaluated on the current flags.
    always_comb begin
        FLAG_cond_true = 1'b1;
        case (FLAG_cond_sel)
            3'b000:  FLAG_cond_true = 1'b1;
            3'b001:  FLAG_cond_true = flag_q[0];
            3'b010:  FLAG_cond_true = ~flag_q[0];
            3'b011:  FLAG_cond_true = flag_q[2];
            3'b100:  FLAG_cond_true = ~flag_q[2];
            3'b101:  FLAG_cond_true = flag_q[1];
            3'b110:  FLAG_cond_true = flag_q[3];
            3'b111:  FLAG_cond_true = ~flag_q[3];
            default: FLAG_cond_true = 1'b1;
        endcase
    end

    assign FLAG_reg         = flag_q;
    assign FLAG_out         = {12'h000, flag_q};
    assign FLAG_stack_full  = is_full;
    assign FLAG_stack_empty = is_empty;
    assign FLAG_stack_err   = err_q;

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have a single clock and asynchronous active-high reset: clk in, rst in.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 FLAG_status_in  input  4  ALU status word: bit0 zero, bit1 all-ones, bit2 carry, bit3 odd parity.
REQ-005 FLAG_update_en  input  1  capture FLAG_status_in into the flag register at the next clk edge.
REQ-006 FLAG_push  input  1  save the current flag register onto the flag stack.
REQ-007 FLAG_pop  input  1  restore the flag register from the top of the flag stack.
REQ-008 FLAG_err_clr  input  1  clear the sticky stack-error flag.
REQ-009 FLAG_cond_sel  input  3  branch condition select.
REQ-010 FLAG_cond_true  output  1  selected condition evaluated on the current flag register.
REQ-011 FLAG_reg  output  4  current flag register.
REQ-012 FLAG_out  output  16  {12'h000, FLAG_reg}, for transfer to the A register.
REQ-013 FLAG_stack_full  output  1  high when the stack holds 4 entries.
REQ-014 FLAG_stack_empty  output  1  high when the stack holds 0 entries.
REQ-015 FLAG_stack_err  output  1  sticky overflow/underflow/conflict indicator.

Function
REQ-016 SHALL hold flags in a 4-bit register with the same bit order as FLAG_status_in.
REQ-017 SHALL implement a 4-entry x 4-bit LIFO with a 3-bit occupancy count, range 0..4.
REQ-018 FLAG_update_en alone: FLAG_reg <= FLAG_status_in at the next edge; 1-cycle latency.
REQ-019 FLAG_push alone, not full: stack[count] <= FLAG_reg; count +1; FLAG_reg unchanged.
REQ-020 FLAG_pop alone, not empty: FLAG_reg <= stack[count-1]; count -1.
REQ-021 Push and update in the same cycle: the old FLAG_reg is pushed and the new FLAG_status_in is captured; both take effect.
REQ-022 Pop and update in the same cycle: pop wins; FLAG_status_in is discarded.
REQ-023 Push and pop in the same cycle: stack and FLAG_reg are unchanged; FLAG_stack_err <= 1; a simultaneous update still applies.
REQ-024 Push when full: push is dropped; count stays 4; FLAG_stack_err <= 1; a simultaneous update still applies.
REQ-025 Pop when empty: FLAG_reg and count are unchanged; FLAG_stack_err <= 1; a simultaneous update still applies.
REQ-026 FLAG_stack_err stays set until FLAG_err_clr; if a clear and a new error occur in the same cycle, the error wins.
REQ-027 FLAG_cond_true is combinational from FLAG_reg:
  - 000 always 1
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 ONES
  - 110 P
  - 111 !P
REQ-028 FLAG_stack_full = (count==4) and FLAG_stack_empty = (count==0), combinational from the count.
REQ-029 There SHALL be no wrap-around: the count saturates, and illegal operations never corrupt stored entries.

Reset
REQ-030 While rst is high, the block SHALL asynchronously hold FLAG_reg=0, count=0, all stack entries=0 and FLAG_stack_err=0.
REQ-031 Reset value of every output SHALL be:
  - FLAG_reg 0, FLAG_out 16'h0000
  - FLAG_stack_empty 1, FLAG_stack_full 0, FLAG_stack_err 0
  - FLAG_cond_true 1 if FLAG_cond_sel is 000, 010, 100 or 111, else 0
REQ-032 Reset asserted mid-operation SHALL discard any pending push, pop or update; the first operation after deassertion is accepted at the first rising edge.

Verification
REQ-033 Update: status_in=4'b0101 with update_en for 1 cycle -> next cycle FLAG_reg=0101, FLAG_out=16'h0005, cond_sel 001 gives 1, cond_sel 100 gives 0.
REQ-034 Push/pop: load 0001, push, load 0100, push, load 1000, pop -> FLAG_reg=0100, count 1; pop again -> 0001, empty=1.
REQ-035 Overflow: 5 pushes of distinct values -> full=1 after the 4th push, err=1 after the 5th; 4 pops return the first 4 values in reverse order.
REQ-036 Underflow and conflict:
  - pop when empty -> err=1, FLAG_reg unchanged; err_clr -> err=0
  - push+pop together -> err=1, count unchanged
REQ-037 Simultaneous ops:
  - push+update (FLAG_reg=0010, status_in=1100) -> stack top 0010, FLAG_reg=1100
  - pop+update -> FLAG_reg = popped value
REQ-038 Async reset: assert rst between clock edges with count=3 -> outputs go to reset values immediately, without waiting for a clk edge.
